// File: rtl/pg_rule_unpacker.sv
// Port-group match stream consumer: buffers 8-lane rule beats, pairs each packet with its
// metadata and serialises non-zero rule IDs, one per cycle, closed by one terminator per packet.
module pg_rule_unpacker #(
   parameter int unsigned FIFO_DEPTH = 64,
   parameter int unsigned AF_THRESH  = 40,
   parameter int unsigned META_W     = 128
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              in_match_valid,
   input  logic              in_match_eop,
   input  logic [127:0]      in_match_data,
   output logic              in_almost_full,
   input  logic              in_meta_valid,
   input  logic [META_W-1:0] in_meta_data,
   output logic              in_meta_ready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_rule_id,
   output logic              out_has_rule,
   output logic              out_last,
   output logic [META_W-1:0] out_meta,
   output logic [31:0]       pkt_cnt,
   output logic [31:0]       rule_cnt,
   output logic              overflow
);

   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {StIdle, StScan, StTerm, StWait} state_e;

   state_e state_q, state_d;

   logic [128:0]      mem_q [FIFO_DEPTH];
   logic [AW:0]       wr_ptr_q, rd_ptr_q, count, count_nxt;
   logic              fifo_empty, fifo_full, push, pop, drop;
   logic [128:0]      fifo_head;
   logic              af_q, overflow_q;

   logic [127:0]      scan_data_q, scan_data_d;
   logic              scan_eop_q, scan_eop_d;
   logic [7:0]        mask_q, mask_d;
   logic [2:0]        lane_sel;

   logic              out_valid_q, out_valid_d, out_has_q, out_has_d, out_last_q, out_last_d;
   logic [15:0]       out_id_q, out_id_d;
   logic              out_free, accept;

   logic              meta_full_q;
   logic [META_W-1:0] meta_q;
   logic [31:0]       pkt_cnt_q, rule_cnt_q;

   assign count      = wr_ptr_q - rd_ptr_q;
   assign fifo_empty = (count == '0);
   assign fifo_full  = (count == (AW+1)'(FIFO_DEPTH));
   assign fifo_head  = mem_q[rd_ptr_q[AW-1:0]];
   // A pop in the same cycle frees the slot, so a write while full still lands.
   assign push       = in_match_valid & (~fifo_full | pop);
   assign drop       = in_match_valid & fifo_full & ~pop;
   assign count_nxt  = count + (AW+1)'(push) - (AW+1)'(pop);

   assign out_free   = ~out_valid_q | out_ready;
   assign accept     = out_valid_q & out_ready;

   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q[AW-1:0]] <= {in_match_eop, in_match_data};
   end

   always_comb begin
      lane_sel = 3'd0;
      for (int i = 7; i >= 0; i--) begin
         if (mask_q[i]) lane_sel = 3'(i);
      end
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      scan_data_d = scan_data_q;
      scan_eop_d  = scan_eop_q;
      mask_d      = mask_q;
      out_valid_d = out_free ? 1'b0 : out_valid_q;
      out_id_d    = out_id_q;
      out_has_d   = out_has_q;
      out_last_d  = out_last_q;
      unique case (state_q)
         StIdle: begin
            if (!fifo_empty && meta_full_q) begin
               pop         = 1'b1;
               scan_data_d = fifo_head[127:0];
               scan_eop_d  = fifo_head[128];
               for (int i = 0; i < 8; i++) mask_d[i] = |fifo_head[16*i +: 16];
               state_d     = StScan;
            end
         end
         StScan: begin
            if (out_free) begin
               if (mask_q != '0) begin
                  out_valid_d = 1'b1;
                  out_id_d    = scan_data_q[16*lane_sel +: 16];
                  out_has_d   = 1'b1;
                  out_last_d  = 1'b0;
                  mask_d      = mask_q & (mask_q - 8'd1);
               end else if (scan_eop_q) begin
                  state_d = StTerm;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         StTerm: begin
            if (out_free) begin
               out_valid_d = 1'b1;
               out_id_d    = 16'd0;
               out_has_d   = 1'b0;
               out_last_d  = 1'b1;
               state_d     = StWait;
            end
         end
         StWait: begin
            // Holding here until the terminator leaves keeps the next packet off stale metadata.
            if (accept && out_last_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         af_q        <= 1'b0;
         overflow_q  <= 1'b0;
         scan_data_q <= '0;
         scan_eop_q  <= 1'b0;
         mask_q      <= '0;
         out_valid_q <= 1'b0;
         out_id_q    <= '0;
         out_has_q   <= 1'b0;
         out_last_q  <= 1'b0;
         meta_full_q <= 1'b0;
         meta_q      <= '0;
         pkt_cnt_q   <= '0;
         rule_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
         af_q        <= (32'(count_nxt) >= AF_THRESH);
         if (drop) overflow_q <= 1'b1;
         scan_data_q <= scan_data_d;
         scan_eop_q  <= scan_eop_d;
         mask_q      <= mask_d;
         out_valid_q <= out_valid_d;
         out_id_q    <= out_id_d;
         out_has_q   <= out_has_d;
         out_last_q  <= out_last_d;
         if (accept && out_last_q) begin
            meta_full_q <= 1'b0;
         end else if (in_meta_valid && !meta_full_q) begin
            meta_full_q <= 1'b1;
            meta_q      <= in_meta_data;
         end
         if (accept && out_last_q) pkt_cnt_q <= pkt_cnt_q + 32'd1;
         if (accept && out_has_q) rule_cnt_q <= rule_cnt_q + 32'd1;
      end
   end

   assign in_almost_full = af_q;
   assign in_meta_ready  = ~meta_full_q;
   assign out_valid      = out_valid_q;
   assign out_rule_id    = out_id_q;
   assign out_has_rule   = out_has_q;
   assign out_last       = out_last_q;
   assign out_meta       = meta_q;
   assign pkt_cnt        = pkt_cnt_q;
   assign rule_cnt       = rule_cnt_q;
   assign overflow       = overflow_q;

endmodule
